// File: rtl/l2_trace_pkg.sv
// Shared types for the L2 trace bus driver: trace command codes, ASCII bus
// operation codes and the request FSM states.
package l2_trace_pkg;

    typedef enum logic [3:0] {
        CMD_DATA_READ   = 4'd0,
        CMD_DATA_WRITE  = 4'd1,
        CMD_INSTR_READ  = 4'd2,
        CMD_SNOOP_INV   = 4'd3,
        CMD_SNOOP_READ  = 4'd4,
        CMD_SNOOP_WRITE = 4'd5,
        CMD_SNOOP_RWITM = 4'd6,
        CMD_RESERVED    = 4'd7,
        CMD_CLEAR       = 4'd8,
        CMD_PRINT       = 4'd9
    } cmd_e;

    localparam logic [15:0] OP_DR = 16'h4452;
    localparam logic [15:0] OP_DW = 16'h4457;
    localparam logic [15:0] OP_IR = 16'h4952;

    localparam logic [7:0] SOP_I = 8'h49;
    localparam logic [7:0] SOP_R = 8'h52;
    localparam logic [7:0] SOP_W = 8'h57;
    localparam logic [7:0] SOP_M = 8'h4D;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        L1_REQ    = 2'd1,
        SNOOP_REQ = 2'd2,
        CTRL      = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_INVALID = 2'd0,
        CLS_L1      = 2'd1,
        CLS_SNOOP   = 2'd2,
        CLS_CTRL    = 2'd3
    } cls_e;

endpackage

// File: rtl/trace_bus_driver_if.sv
// Trace input handshake plus the L1 request bus and shared snoop bus.
// Address/operation lines are nets so an idle bus can float.
interface trace_bus_driver_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CMD_WIDTH  = 4
);
    logic                  traceValid;
    logic                  traceReady;
    logic [CMD_WIDTH-1:0]  traceCommand;
    logic [ADDR_WIDTH-1:0] traceAddress;

    wire  [ADDR_WIDTH-1:0] l1Address;
    wire  [15:0]           l1Operation;
    logic                  l1Valid;
    logic                  l1Ack;

    wire  [ADDR_WIDTH-1:0] snoopAddress;
    wire  [7:0]            snoopOperation;
    logic                  snoopValid;
    logic                  snoopAck;

    modport master (
        output traceValid, traceCommand, traceAddress, l1Ack, snoopAck,
        input  traceReady, l1Address, l1Operation, l1Valid,
               snoopAddress, snoopOperation, snoopValid
    );

    modport slave (
        input  traceValid, traceCommand, traceAddress, l1Ack, snoopAck,
        output traceReady, l1Address, l1Operation, l1Valid,
               snoopAddress, snoopOperation, snoopValid
    );
endinterface

// File: rtl/trace_fifo.sv
// Show-ahead record FIFO; the head entry is visible on rdata while non-empty.
// Pointers carry one extra bit so full and empty are distinguishable.
module trace_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_r;
    logic [AW:0]      rptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_s;
    logic             pop_s;

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign empty  = (wptr_r == rptr_r);
    assign full   = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign rdata  = mem_r[rptr_r[AW-1:0]];

    // Read/write pointer update
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_r <= {(AW+1){1'b0}};
            rptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

    // Record storage
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/trace_bus_driver.sv
// Replays buffered trace records onto the L1 request bus, the snoop bus or
// the cache control pulses, keeping issued/discarded record statistics.
module trace_bus_driver
    import l2_trace_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int CMD_WIDTH   = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    trace_bus_driver_if.slave      bus,
    output logic                   clearCache,
    output logic                   printCache,
    output logic [COUNT_WIDTH-1:0] requestCount,
    output logic [COUNT_WIDTH-1:0] invalidCount,
    output logic                   busy
);
    localparam int REC_WIDTH = CMD_WIDTH + ADDR_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   fifo_push_s;
    logic                   fifo_pop_s;
    logic [REC_WIDTH-1:0]   fifo_rdata_s;
    logic [CMD_WIDTH-1:0]   head_cmd_s;
    logic [ADDR_WIDTH-1:0]  head_addr_s;
    cls_e                   head_class_s;
    logic [15:0]            l1_op_s;
    logic [7:0]             snoop_op_s;
    logic                   req_inc_s;
    logic                   inv_inc_s;

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [ADDR_WIDTH-1:0]  addr_r;
    logic [15:0]            l1_op_r;
    logic [7:0]             snoop_op_r;
    logic                   l1_valid_r;
    logic                   snoop_valid_r;
    logic                   clear_r;
    logic                   print_r;
    logic [COUNT_WIDTH-1:0] request_count_r;
    logic [COUNT_WIDTH-1:0] invalid_count_r;

    assign fifo_push_s = bus.traceValid && !fifo_full_s;
    assign head_cmd_s  = fifo_rdata_s[REC_WIDTH-1:ADDR_WIDTH];
    assign head_addr_s = fifo_rdata_s[ADDR_WIDTH-1:0];

    trace_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push_s),
        .wdata ({bus.traceCommand, bus.traceAddress}),
        .full  (fifo_full_s),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .empty (fifo_empty_s)
    );

    // Classify the FIFO head record and pick its bus operation code
    always_comb begin
        head_class_s = CLS_INVALID;
        l1_op_s      = 16'h0000;
        snoop_op_s   = 8'h00;
        case (head_cmd_s)
            CMD_WIDTH'(CMD_DATA_READ):   begin head_class_s = CLS_L1;    l1_op_s    = OP_DR; end
            CMD_WIDTH'(CMD_DATA_WRITE):  begin head_class_s = CLS_L1;    l1_op_s    = OP_DW; end
            CMD_WIDTH'(CMD_INSTR_READ):  begin head_class_s = CLS_L1;    l1_op_s    = OP_IR; end
            CMD_WIDTH'(CMD_SNOOP_INV):   begin head_class_s = CLS_SNOOP; snoop_op_s = SOP_I; end
            CMD_WIDTH'(CMD_SNOOP_READ):  begin head_class_s = CLS_SNOOP; snoop_op_s = SOP_R; end
            CMD_WIDTH'(CMD_SNOOP_WRITE): begin head_class_s = CLS_SNOOP; snoop_op_s = SOP_W; end
            CMD_WIDTH'(CMD_SNOOP_RWITM): begin head_class_s = CLS_SNOOP; snoop_op_s = SOP_M; end
            CMD_WIDTH'(CMD_CLEAR):       head_class_s = CLS_CTRL;
            CMD_WIDTH'(CMD_PRINT):       head_class_s = CLS_CTRL;
            default:                     head_class_s = CLS_INVALID;
        endcase
    end

    // Next-state logic; acks only matter while the matching request is up
    always_comb begin
        state_nxt_s = state_r;
        fifo_pop_s  = 1'b0;
        req_inc_s   = 1'b0;
        inv_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    case (head_class_s)
                        CLS_L1:    state_nxt_s = L1_REQ;
                        CLS_SNOOP: state_nxt_s = SNOOP_REQ;
                        CLS_CTRL:  state_nxt_s = CTRL;
                        default: begin
                            state_nxt_s = IDLE;
                            inv_inc_s   = 1'b1;
                        end
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            L1_REQ: begin
                if (bus.l1Ack) begin
                    state_nxt_s = IDLE;
                    req_inc_s   = 1'b1;
                end else begin
                    state_nxt_s = L1_REQ;
                end
            end
            SNOOP_REQ: begin
                if (bus.snoopAck) begin
                    state_nxt_s = IDLE;
                    req_inc_s   = 1'b1;
                end else begin
                    state_nxt_s = SNOOP_REQ;
                end
            end
            CTRL: begin
                state_nxt_s = IDLE;
                req_inc_s   = 1'b1;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, registered bus strobes and captured request payload
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            l1_valid_r    <= 1'b0;
            snoop_valid_r <= 1'b0;
            clear_r       <= 1'b0;
            print_r       <= 1'b0;
            addr_r        <= {ADDR_WIDTH{1'b0}};
            l1_op_r       <= 16'h0000;
            snoop_op_r    <= 8'h00;
        end else begin
            state_r       <= state_nxt_s;
            l1_valid_r    <= (state_nxt_s == L1_REQ);
            snoop_valid_r <= (state_nxt_s == SNOOP_REQ);
            clear_r       <= fifo_pop_s && (head_class_s == CLS_CTRL)
                             && (head_cmd_s == CMD_WIDTH'(CMD_CLEAR));
            print_r       <= fifo_pop_s && (head_class_s == CLS_CTRL)
                             && (head_cmd_s == CMD_WIDTH'(CMD_PRINT));
            if (fifo_pop_s) begin
                addr_r     <= head_addr_s;
                l1_op_r    <= l1_op_s;
                snoop_op_r <= snoop_op_s;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clock) begin
        if (reset) begin
            request_count_r <= {COUNT_WIDTH{1'b0}};
            invalid_count_r <= {COUNT_WIDTH{1'b0}};
        end else begin
            if (req_inc_s && (request_count_r != CNT_MAX)) begin
                request_count_r <= request_count_r + CNT_ONE;
            end
            if (inv_inc_s && (invalid_count_r != CNT_MAX)) begin
                invalid_count_r <= invalid_count_r + CNT_ONE;
            end
        end
    end

    assign bus.traceReady     = !fifo_full_s;
    assign bus.l1Valid        = l1_valid_r;
    assign bus.l1Address      = l1_valid_r ? addr_r : {ADDR_WIDTH{1'bz}};
    assign bus.l1Operation    = l1_valid_r ? l1_op_r : 16'hzzzz;
    assign bus.snoopValid     = snoop_valid_r;
    assign bus.snoopAddress   = snoop_valid_r ? addr_r : {ADDR_WIDTH{1'bz}};
    assign bus.snoopOperation = snoop_valid_r ? snoop_op_r : 8'hzz;

    assign clearCache   = clear_r;
    assign printCache   = print_r;
    assign requestCount = request_count_r;
    assign invalidCount = invalid_count_r;
    assign busy         = !fifo_empty_s || (state_r != IDLE);
endmodule

// File: tb/tb_trace_bus_driver.sv
// Directed bench for trace_bus_driver: a vector table of single records plus
// hand-written sequences for stalls, FIFO backpressure, reset and saturation.
module tb_trace_bus_driver;
    localparam int AW = 32;
    localparam int CW = 4;
    localparam int FD = 8;
    localparam int NW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          clear_cache;
    logic          print_cache;
    logic          busy;
    logic [NW-1:0] request_count;
    logic [NW-1:0] invalid_count;

    trace_bus_driver_if #(.ADDR_WIDTH(AW), .CMD_WIDTH(CW)) bus_if ();

    trace_bus_driver #(
        .ADDR_WIDTH  (AW),
        .CMD_WIDTH   (CW),
        .FIFO_DEPTH  (FD),
        .COUNT_WIDTH (NW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus_if.slave),
        .clearCache   (clear_cache),
        .printCache   (print_cache),
        .requestCount (request_count),
        .invalidCount (invalid_count),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] addr;
        logic        exp_l1;
        logic        exp_snoop;
        logic        exp_clear;
        logic        exp_print;
        logic [15:0] exp_l1op;
        logic [7:0]  exp_sop;
        logic [3:0]  exp_req;
        logic [3:0]  exp_inv;
    } vec_t;

    vec_t vecs [12];
    int   compared   = 0;
    int   mismatched = 0;
    int   accepted;
    int   seen;
    logic rdy;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic float32(input logic [31:0] v);
        return (v === 32'hzzzz_zzzz) || (v === 32'h0000_0000);
    endfunction
    function automatic logic float16(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction
    function automatic logic float8(input logic [7:0] v);
        return (v === 8'hzz) || (v === 8'h00);
    endfunction

    task automatic check_float(input string name, input logic ok, input logic [31:0] act);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: got %h, expected high-impedance", name, act);
        end
    endtask

    task automatic check_l1(input string tag, input logic exp_v, input logic [31:0] exp_a,
                            input logic [15:0] exp_op);
        check({tag, " l1Valid"}, bus_if.l1Valid, exp_v);
        if (exp_v) begin
            check({tag, " l1Address"}, bus_if.l1Address, exp_a);
            check({tag, " l1Operation"}, bus_if.l1Operation, exp_op);
        end else begin
            check_float({tag, " l1Address"}, float32(bus_if.l1Address), bus_if.l1Address);
            check_float({tag, " l1Operation"}, float16(bus_if.l1Operation), {16'h0, bus_if.l1Operation});
        end
    endtask

    task automatic check_snoop(input string tag, input logic exp_v, input logic [31:0] exp_a,
                               input logic [7:0] exp_op);
        check({tag, " snoopValid"}, bus_if.snoopValid, exp_v);
        if (exp_v) begin
            check({tag, " snoopAddress"}, bus_if.snoopAddress, exp_a);
            check({tag, " snoopOperation"}, bus_if.snoopOperation, exp_op);
        end else begin
            check_float({tag, " snoopAddress"}, float32(bus_if.snoopAddress), bus_if.snoopAddress);
            check_float({tag, " snoopOperation"}, float8(bus_if.snoopOperation), {24'h0, bus_if.snoopOperation});
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " traceReady"}, bus_if.traceReady, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " clearCache"}, clear_cache, 1'b0);
        check({tag, " printCache"}, print_cache, 1'b0);
        check({tag, " requestCount"}, request_count, 4'd0);
        check({tag, " invalidCount"}, invalid_count, 4'd0);
        check_l1(tag, 1'b0, 32'h0, 16'h0);
        check_snoop(tag, 1'b0, 32'h0, 8'h0);
    endtask

    initial begin
        reset                = 1'b1;
        bus_if.traceValid    = 1'b0;
        bus_if.traceCommand  = 4'd0;
        bus_if.traceAddress  = 32'h0;
        bus_if.l1Ack         = 1'b0;
        bus_if.snoopAck      = 1'b0;

        vecs[0]  = '{4'd0,  32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0, "DR",  8'h00, 4'd1, 4'd0};
        vecs[1]  = '{4'd1,  32'hA000_0004, 1'b1, 1'b0, 1'b0, 1'b0, "DW",  8'h00, 4'd2, 4'd0};
        vecs[2]  = '{4'd2,  32'h0000_0FFC, 1'b1, 1'b0, 1'b0, 1'b0, "IR",  8'h00, 4'd3, 4'd0};
        vecs[3]  = '{4'd3,  32'h1111_0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, "I",   4'd4, 4'd0};
        vecs[4]  = '{4'd4,  32'h2222_0040, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, "R",   4'd5, 4'd0};
        vecs[5]  = '{4'd5,  32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, "W",   4'd6, 4'd0};
        vecs[6]  = '{4'd6,  32'hFFFF_FFC0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, "M",   4'd7, 4'd0};
        vecs[7]  = '{4'd7,  32'h0000_0700, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 4'd7, 4'd1};
        vecs[8]  = '{4'd12, 32'h0000_0C00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 4'd7, 4'd2};
        vecs[9]  = '{4'd8,  32'h0000_0800, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h00, 4'd8, 4'd2};
        vecs[10] = '{4'd9,  32'h0000_0900, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 8'h00, 4'd9, 4'd2};
        vecs[11] = '{4'd15, 32'h0000_0F00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00, 4'd9, 4'd3};

        tick();
        tick();
        check_reset_state("reset");

        // Table: one record at a time, acks tied high
        reset         = 1'b0;
        bus_if.l1Ack    = 1'b1;
        bus_if.snoopAck = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus_if.traceValid   = 1'b1;
            bus_if.traceCommand = vecs[i].cmd;
            bus_if.traceAddress = vecs[i].addr;
            tick();
            bus_if.traceValid = 1'b0;
            check($sformatf("v%0d busy after push", i), busy, 1'b1);
            tick();
            check_l1($sformatf("v%0d issue", i), vecs[i].exp_l1, vecs[i].addr, vecs[i].exp_l1op);
            check_snoop($sformatf("v%0d issue", i), vecs[i].exp_snoop, vecs[i].addr, vecs[i].exp_sop);
            check($sformatf("v%0d clearCache", i), clear_cache, vecs[i].exp_clear);
            check($sformatf("v%0d printCache", i), print_cache, vecs[i].exp_print);
            tick();
            check($sformatf("v%0d l1Valid done", i), bus_if.l1Valid, 1'b0);
            check($sformatf("v%0d snoopValid done", i), bus_if.snoopValid, 1'b0);
            check($sformatf("v%0d clear pulse end", i), clear_cache, 1'b0);
            check($sformatf("v%0d print pulse end", i), print_cache, 1'b0);
            check($sformatf("v%0d requestCount", i), request_count, vecs[i].exp_req);
            check($sformatf("v%0d invalidCount", i), invalid_count, vecs[i].exp_inv);
            check($sformatf("v%0d busy idle", i), busy, 1'b0);
        end

        // Snoop request stalled by a late ack holds the bus steady
        bus_if.l1Ack        = 1'b0;
        bus_if.snoopAck     = 1'b0;
        bus_if.traceValid   = 1'b1;
        bus_if.traceCommand = 4'd5;
        bus_if.traceAddress = 32'hDEAD_BEEF;
        tick();
        bus_if.traceValid = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check_snoop($sformatf("stall c%0d", k), 1'b1, 32'hDEAD_BEEF, "W");
            check_l1($sformatf("stall c%0d", k), 1'b0, 32'h0, 16'h0);
            if (k < 4) tick();
        end
        bus_if.snoopAck = 1'b1;
        tick();
        check("stall released snoopValid", bus_if.snoopValid, 1'b0);
        check("stall requestCount", request_count, 4'd10);

        // FIFO backpressure: hold one L1 request unacked, then offer 9 more
        bus_if.snoopAck     = 1'b0;
        bus_if.traceValid   = 1'b1;
        bus_if.traceCommand = 4'd0;
        bus_if.traceAddress = 32'h0000_0100;
        tick();
        bus_if.traceValid = 1'b0;
        tick();
        check_l1("held", 1'b1, 32'h0000_0100, "DR");
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            bus_if.traceAddress = 32'h0000_0200 + 32'(accepted * 4);
            bus_if.traceValid   = 1'b1;
            rdy = bus_if.traceReady;
            tick();
            if (rdy) accepted++;
        end
        check("accepted before ack", accepted, 8);
        check("traceReady when full", bus_if.traceReady, 1'b0);
        check("held l1Address while full", bus_if.l1Address, 32'h0000_0100);
        bus_if.l1Ack = 1'b1;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            rdy = bus_if.traceReady;
            tick();
            if (bus_if.traceValid && rdy) begin
                accepted++;
                bus_if.traceValid = 1'b0;
            end
            if (bus_if.l1Valid) begin
                check($sformatf("drain order %0d", seen), bus_if.l1Address,
                      32'h0000_0200 + 32'(seen * 4));
                seen++;
            end
            if (!busy && !bus_if.traceValid) break;
        end
        check("accepted after ack", accepted, 9);
        check("records drained", seen, 9);
        check("requestCount saturated", request_count, 4'hF);
        check("busy after drain", busy, 1'b0);

        // Reset in the middle of an unacked snoop request
        bus_if.l1Ack        = 1'b0;
        bus_if.snoopAck     = 1'b0;
        bus_if.traceValid   = 1'b1;
        bus_if.traceCommand = 4'd4;
        bus_if.traceAddress = 32'h0000_4000;
        tick();
        bus_if.traceValid = 1'b0;
        tick();
        check("pre-reset snoopValid", bus_if.snoopValid, 1'b1);
        reset               = 1'b1;
        bus_if.traceValid   = 1'b1;
        bus_if.traceCommand = 4'd0;
        bus_if.traceAddress = 32'h0000_5000;
        tick();
        bus_if.traceValid = 1'b0;
        check_reset_state("mid reset");
        reset           = 1'b0;
        bus_if.snoopAck = 1'b1;
        tick();
        tick();
        check("post reset snoopValid", bus_if.snoopValid, 1'b0);
        check("post reset l1Valid", bus_if.l1Valid, 1'b0);
        check("post reset requestCount", request_count, 4'd0);
        check("post reset busy", busy, 1'b0);

        // Invalid-count saturation with back-to-back discarded records
        for (int k = 0; k < 17; k++) begin
            bus_if.traceValid   = 1'b1;
            bus_if.traceCommand = (k % 2 == 0) ? 4'd7 : 4'd13;
            bus_if.traceAddress = 32'(k);
            tick();
        end
        bus_if.traceValid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!busy) break;
            tick();
        end
        check("saturate busy", busy, 1'b0);
        check("invalidCount saturated", invalid_count, 4'hF);
        check("saturate requestCount", request_count, 4'd0);
        check_l1("saturate", 1'b0, 32'h0, 16'h0);
        check_snoop("saturate", 1'b0, 32'h0, 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
